// File: rtl/ladd_pipe.sv
// ladd_pipe: running-sum accumulator split into S-bit slices, one slice per pipeline stage, deskewed to a coherent output.
// Macro LADD_PIPE_OVF_EN builds the sticky overflow flag; without it ovf is tied to 0.
module ladd_pipe #(
    parameter int W = 16,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         clr,
    input  logic [W-1:0] x,
    output logic [W-1:0] a,
    output logic         out_valid,
    output logic         ovf
);
    localparam int N = W / S;

`ifdef LADD_PIPE_OVF_EN
    localparam bit OVF_EN = 1'b1;
    logic [N:0]   w_cin;
`else
    localparam bit OVF_EN = 1'b0;
    logic [N-1:0] w_cin;
`endif

    // Token tags and addend travel together; index k is what slice k sees at the next edge.
    logic         r_tv [0:N];
    logic         r_tc [0:N];
    logic [W-1:0] r_xp [0:N-1];
    logic [W-1:0] w_out;
    logic [W-1:0] r_a;
    logic         r_out_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= N; k++) begin
                r_tv[k] <= 1'b0;
                r_tc[k] <= 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                r_xp[k] <= '0;
            end
        end else begin
            r_tv[0] <= in_valid | clr;
            r_tc[0] <= clr;
            r_xp[0] <= in_valid ? x : '0;
            for (int k = 1; k <= N; k++) begin
                r_tv[k] <= r_tv[k-1];
                r_tc[k] <= r_tc[k-1];
            end
            for (int k = 1; k < N; k++) begin
                r_xp[k] <= r_xp[k-1];
            end
        end
    end

    assign w_cin[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            localparam bit HAS_CY = (gi < N - 1) || OVF_EN;
            logic [S-1:0] r_acc;
            logic [S-1:0] w_base;
            logic [S-1:0] w_xs;
            logic [S-1:0] w_res;

            // A clr token loads the slice instead of adding to it.
            assign w_base = r_tc[gi] ? '0 : r_acc;
            assign w_xs   = r_xp[gi][gi*S +: S];

            if (HAS_CY) begin : g_cy
                logic [S:0] w_sum;
                logic       r_cy;
                assign w_sum = {1'b0, w_base} + {1'b0, w_xs} + (S+1)'(w_cin[gi]);
                assign w_res = w_sum[S-1:0];
                assign w_cin[gi+1] = r_cy;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_cy <= 1'b0;
                    end else if (r_tv[gi]) begin
                        r_cy <= w_sum[S];
                    end
                end
            end else begin : g_nocy
                assign w_res = w_base + w_xs + S'(w_cin[gi]);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_tv[gi]) begin
                    r_acc <= w_res;
                end
            end

            // Lower slices finish earlier and wait here so the whole word lands together.
            if (gi < N - 1) begin : g_dsk
                localparam int D = N - 1 - gi;
                logic [S-1:0] r_dsk [0:D-1];
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int j = 0; j < D; j++) begin
                            r_dsk[j] <= '0;
                        end
                    end else begin
                        r_dsk[0] <= r_acc;
                        for (int j = 1; j < D; j++) begin
                            r_dsk[j] <= r_dsk[j-1];
                        end
                    end
                end
                assign w_out[gi*S +: S] = r_dsk[D-1];
            end else begin : g_nodsk
                assign w_out[gi*S +: S] = r_acc;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_tv[N];
            if (r_tv[N]) begin
                r_a <= w_out;
            end
        end
    end

    assign a         = r_a;
    assign out_valid = r_out_valid;

`ifdef LADD_PIPE_OVF_EN
    logic r_ovf;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_tv[N]) begin
            r_ovf <= w_cin[N] | (r_ovf & ~r_tc[N]);
        end
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ladd_pipe.sv
// Testbench for ladd_pipe: directed scenarios plus a randomized run against an arithmetic running-sum model.
// Honours LADD_PIPE_OVF_EN for the expected ovf value.
module tb_ladd_pipe;

`ifdef LADD_PIPE_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] a;
    logic        out_valid;
    logic        ovf;
    logic        in_valid8 = 1'b0;
    logic        clr8 = 1'b0;
    logic [7:0]  x8 = '0;
    logic [7:0]  a8;
    logic        out_valid8;
    logic        ovf8;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [15:0] a;
        logic        o;
        int          due;
    } exp_t;

    always #5 clk = ~clk;

    ladd_pipe #(.W(16), .S(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .clr(clr), .x(x),
        .a(a), .out_valid(out_valid), .ovf(ovf)
    );

    ladd_pipe #(.W(8), .S(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .clr(clr8), .x(x8),
        .a(a8), .out_valid(out_valid8), .ovf(ovf8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; x = '0;
        in_valid8 = 1'b0; clr8 = 1'b0; x8 = '0;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        int pulses = 0;
        rst = 1'b1; in_valid = 1'b1; clr = 1'b1; x = 16'h1234;
        in_valid8 = 1'b1; x8 = 8'h55;
        repeat (2) tick();
        rst = 1'b0; in_valid = 1'b0; clr = 1'b0; x = '0; in_valid8 = 1'b0; x8 = '0;
        n_checks++; if (a !== 16'h0) $display("FAIL reset_a got %h want 0000", a); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
        n_checks++; if (a8 !== 8'h0) $display("FAIL reset_a8 got %h want 00", a8); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (out_valid === 1'b1 || out_valid8 === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL reset_priority pulses got %0d want 0", pulses); else n_pass++;
    endtask

    task automatic test_single();
        do_reset(2);
        in_valid = 1'b1; x = 16'h0001;
        for (int r = 0; r < 7; r++) begin
            tick();
            in_valid = 1'b0; x = '0;
            n_checks++;
            if (out_valid !== (r == 5)) $display("FAIL single_valid r=%0d got %b want %b", r, out_valid, (r == 5));
            else n_pass++;
            if (r == 5) begin
                n_checks++; if (a !== 16'h0001) $display("FAIL single_a got %h want 0001", a); else n_pass++;
                n_checks++; if (ovf !== 1'b0) $display("FAIL single_ovf got %b want 0", ovf); else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] xs [3] = '{16'h000F, 16'h0001, 16'h00F0};
        logic [15:0] ea [3] = '{16'h000F, 16'h0010, 16'h0100};
        do_reset(2);
        for (int r = 0; r < 9; r++) begin
            in_valid = 1'b0; x = '0;
            if (r < 3) begin in_valid = 1'b1; x = xs[r]; end
            tick();
            n_checks++;
            if (out_valid !== (r >= 5 && r < 8)) $display("FAIL b2b_valid r=%0d got %b", r, out_valid);
            else n_pass++;
            if (r >= 5 && r < 8) begin
                n_checks++;
                if (a !== ea[r-5]) $display("FAIL b2b_a r=%0d got %h want %h", r, a, ea[r-5]); else n_pass++;
            end
        end
        in_valid = 1'b0; x = '0;
    endtask

    task automatic test_ovf();
        logic        tv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [15:0] tx [4] = '{16'hFFFF, 16'h0002, 16'h0001, 16'h0000};
        logic [15:0] ea [4] = '{16'hFFFF, 16'h0001, 16'h0002, 16'h0000};
        logic        eo [4] = '{1'b0, OVF, OVF, 1'b0};
        do_reset(2);
        for (int r = 0; r < 10; r++) begin
            in_valid = 1'b0; clr = 1'b0; x = '0;
            if (r < 4) begin in_valid = tv[r]; clr = tc[r]; x = tx[r]; end
            tick();
            n_checks++;
            if (out_valid !== (r >= 5 && r < 9)) $display("FAIL ovf_valid r=%0d got %b", r, out_valid);
            else n_pass++;
            if (r >= 5 && r < 9) begin
                n_checks++;
                if (a !== ea[r-5]) $display("FAIL ovf_a r=%0d got %h want %h", r, a, ea[r-5]); else n_pass++;
                n_checks++;
                if (ovf !== eo[r-5]) $display("FAIL ovf_flag r=%0d got %b want %b", r, ovf, eo[r-5]); else n_pass++;
            end
        end
    endtask

    task automatic test_clr();
        logic        tv [3] = '{1'b1, 1'b1, 1'b0};
        logic        tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [15:0] tx [3] = '{16'h0003, 16'h0005, 16'h0000};
        logic [15:0] ea [3] = '{16'h0003, 16'h0005, 16'h0000};
        do_reset(2);
        for (int r = 0; r < 9; r++) begin
            in_valid = 1'b0; clr = 1'b0; x = '0;
            if (r < 3) begin in_valid = tv[r]; clr = tc[r]; x = tx[r]; end
            tick();
            n_checks++;
            if (out_valid !== (r >= 5 && r < 8)) $display("FAIL clr_valid r=%0d got %b", r, out_valid);
            else n_pass++;
            if (r >= 5 && r < 8) begin
                n_checks++;
                if (a !== ea[r-5]) $display("FAIL clr_a r=%0d got %h want %h", r, a, ea[r-5]); else n_pass++;
                n_checks++;
                if (ovf !== 1'b0) $display("FAIL clr_ovf r=%0d got %b want 0", r, ovf); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        do_reset(2);
        for (int r = 0; r < 3; r++) begin
            in_valid = 1'b1; x = 16'($urandom_range(1, 16'hFFFF));
            tick();
        end
        in_valid = 1'b0; x = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses != 0) $display("FAIL inflight_pulses got %0d want 0", pulses); else n_pass++;
        n_checks++; if (a !== 16'h0) $display("FAIL inflight_a got %h want 0000", a); else n_pass++;
        in_valid = 1'b1; x = 16'h0007;
        for (int r = 0; r < 6; r++) begin
            tick();
            in_valid = 1'b0; x = '0;
            n_checks++;
            if (out_valid !== (r == 5)) $display("FAIL after_rst_valid r=%0d got %b", r, out_valid); else n_pass++;
        end
        n_checks++; if (a !== 16'h0007) $display("FAIL after_rst_a got %h want 0007", a); else n_pass++;
    endtask

    task automatic test_random();
        exp_t        q[$];
        exp_t        e;
        logic [15:0] m_sum = '0;
        logic        m_ovf = 1'b0;
        logic [16:0] wide;
        logic [15:0] last_a = '0;
        logic        last_o = 1'b0;
        logic [15:0] addend;
        logic        tok;
        do_reset(2);
        for (int c = 0; c < 408; c++) begin
            in_valid = 1'b0; clr = 1'b0; x = '0;
            if (c < 400) begin
                in_valid = ($urandom_range(0, 2) != 0);
                clr      = ($urandom_range(0, 11) == 0);
                x        = ($urandom_range(0, 3) == 0) ? (16'hF000 | 16'($urandom)) : 16'($urandom);
            end
            tok    = in_valid | clr;
            addend = in_valid ? x : 16'h0;
            tick();
            if (tok) begin
                if (clr) begin
                    m_sum = addend;
                    m_ovf = 1'b0;
                end else begin
                    wide  = {1'b0, m_sum} + {1'b0, addend};
                    m_sum = wide[15:0];
                    m_ovf = m_ovf | wide[16];
                end
                e.a = m_sum; e.o = m_ovf & OVF; e.due = c + 5;
                q.push_back(e);
            end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                n_checks++; if (out_valid !== 1'b1) $display("FAIL rand_valid c=%0d got %b want 1", c, out_valid); else n_pass++;
                n_checks++; if (a !== e.a) $display("FAIL rand_a c=%0d got %h want %h", c, a, e.a); else n_pass++;
                n_checks++; if (ovf !== e.o) $display("FAIL rand_ovf c=%0d got %b want %b", c, ovf, e.o); else n_pass++;
                last_a = e.a; last_o = e.o;
            end else begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL rand_idle c=%0d got %b want 0", c, out_valid); else n_pass++;
                n_checks++; if (a !== last_a || ovf !== last_o)
                    $display("FAIL rand_hold c=%0d got %h/%b want %h/%b", c, a, ovf, last_a, last_o);
                else n_pass++;
            end
        end
        n_checks++; if (q.size() != 0) $display("FAIL rand_drain left %0d want 0", q.size()); else n_pass++;
    endtask

    task automatic test_n1();
        do_reset(2);
        in_valid8 = 1'b1; x8 = 8'hFF;
        tick();
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL n1_early0 got %b want 0", out_valid8); else n_pass++;
        x8 = 8'h01;
        tick();
        n_checks++; if (out_valid8 !== 1'b0) $display("FAIL n1_early1 got %b want 0", out_valid8); else n_pass++;
        in_valid8 = 1'b0; x8 = '0;
        tick();
        n_checks++; if (out_valid8 !== 1'b1 || a8 !== 8'hFF || ovf8 !== 1'b0)
            $display("FAIL n1_first got %b/%h/%b want 1/ff/0", out_valid8, a8, ovf8);
        else n_pass++;
        tick();
        n_checks++; if (out_valid8 !== 1'b1 || a8 !== 8'h00 || ovf8 !== OVF)
            $display("FAIL n1_second got %b/%h/%b want 1/00/%b", out_valid8, a8, ovf8, OVF);
        else n_pass++;
        tick();
        n_checks++; if (out_valid8 !== 1'b0 || a8 !== 8'h00)
            $display("FAIL n1_hold got %b/%h want 0/00", out_valid8, a8);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_ovf();
        test_clr();
        test_reset_inflight();
        test_random();
        test_n1();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ladd_pipe.md
LADD_PIPE -- requirements
Module: ladd_pipe

Interface
REQ-001 The block SHALL have parameter W, default 16, accumulator width in bits.
REQ-002 The block SHALL have parameter S, default 4, slice width in bits; W SHALL be an integer multiple of S, S>=1; N=W/S slices.
REQ-003 The block SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port in_valid  input  1  x is a term to accumulate this cycle.
REQ-006 The block SHALL have port clr  input  1  restart the running sum with this token.
REQ-007 The block SHALL have port x  input  W  addend.
REQ-008 The block SHALL have port a  output  W  coherent running sum, registered.
REQ-009 The block SHALL have port out_valid  output  1  a (and ovf) updated for one token this cycle.
REQ-010 The block SHALL have port ovf  output  1  sticky overflow of the current sum.

Function
REQ-011 A token SHALL be accepted on every edge where in_valid|clr is 1; no backpressure, throughput one token per cycle.
REQ-012 Token addend SHALL be x when in_valid=1, else 0.
REQ-013 Token SHALL be registered at edge T (input stage), S-bit slice k SHALL be added at edge T+1+k, with x slice k delayed k cycles to align.
REQ-014 Carry out of slice k SHALL be registered and consumed by slice k+1 together with the same token one cycle later; top-slice carry SHALL feed ovf only.
REQ-015 Each token SHALL carry its clr flag down the pipeline; slice k with clr flag SHALL load (addend slice + 0 + incoming carry, where carry is 0 for slice 0) instead of adding to its accumulator.
REQ-016 Slice k result SHALL pass through N-1-k deskew registers so all slices of a token reach the output register together.
REQ-017 a and out_valid SHALL update at edge T+N+1 (latency N+1 cycles; 5 at defaults); out_valid SHALL be high exactly one cycle per token.
REQ-018 a SHALL equal the modulo-2^W sum of all addends from the most recent clr token through this token, inclusive.
REQ-019 When out_valid=0, a and ovf SHALL hold their previous values.
REQ-020 in_valid=1 and clr=1 in same cycle SHALL start a new sum whose first term is x.
REQ-021 N=1 (S=W) SHALL be legal; latency 2.

Reset
REQ-022 rst=1 at an edge SHALL zero all slice accumulators, carry registers, valid/clr tags, deskew registers, a, out_valid and ovf; it has priority over in_valid and clr.
REQ-023 Tokens in flight at reset SHALL be discarded with no out_valid pulse; the first token after reset SHALL start from sum 0.

Configuration
REQ-024 With macro LADD_PIPE_OVF_EN defined, ovf SHALL be set with the token whose top-slice carry-out is 1, SHALL stay set for later tokens, and SHALL be cleared by a clr token (then set only by that token's own carry).
REQ-025 Without LADD_PIPE_OVF_EN, ovf SHALL be constant 0 and no ovf/top-carry storage SHALL be built; all other behaviour identical.

Verification (W=16, S=4 unless noted)
REQ-026 rst 2 cycles, then one token in_valid=1 x=0x0001 -> exactly one out_valid 5 cycles later, a=0x0001, ovf=0.
REQ-027 Back-to-back x=0x000F,0x0001,0x00F0 -> out_valid 3 consecutive cycles, a=0x000F,0x0010,0x0100.
REQ-028 With OVF_EN: x=0xFFFF then 0x0002 -> a=0xFFFF ovf=0, then a=0x0001 ovf=1; further x=0x0001 -> a=0x0002 ovf=1; clr token alone -> a=0x0000 ovf=0.
REQ-029 x=0x0003 then next cycle in_valid=1 clr=1 x=0x0005 -> a=0x0003 then a=0x0005; clr=1 in_valid=0 -> a=0x0000 with out_valid pulse.
REQ-030 Three tokens in flight, rst pulsed one cycle -> no out_valid, a=0; next token x=0x0007 -> a=0x0007 after 5 cycles.
REQ-031 W=8, S=8: x=0xFF then 0x01 -> latency 2, a=0xFF then 0x00, ovf=1 with OVF_EN, 0 without.
